// File: rtl/spi_gate_burst_pkg.sv
// spi_gate_burst_pkg: state encoding, fetch length and parameter helpers for the SPI gateway.
package spi_gate_burst_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LOAD, ST_DATA} state_t;
    localparam int TXE_CYCLES = 2;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
    function automatic bit cfg_ok(input int addr_w, input int data_w, input int sync_stages);
        return addr_w >= 1 && addr_w <= 16 && data_w >= 8 && data_w <= 32 && data_w % 8 == 0 &&
               sync_stages >= 2 && sync_stages <= 3;
    endfunction
endpackage

// File: rtl/spi_gate_burst_if.sv
// spi_gate_burst_if: host SPI pins plus the register port bus of the gateway.
interface spi_gate_burst_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic sclk, mosi, miso, n_cs, sel, txe, rxe;
    logic [DATA_W-1:0] rxd, txd;
    logic [ADDR_W-1:0] addr;
    modport master (output sclk, mosi, n_cs, txd, input miso, rxd, addr, sel, txe, rxe);
    modport slave (input sclk, mosi, n_cs, txd, output miso, rxd, addr, sel, txe, rxe);
endinterface

// File: rtl/spi_gate_burst_sync.sv
// spi_sync: flop chain bringing one asynchronous SPI pin into the clk domain.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] pipe;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) pipe <= {STAGES{RST_VAL}};
        else pipe <= {pipe[STAGES-2:0], d};
    assign q = pipe[STAGES-1];
endmodule

// File: rtl/spi_gate_burst.sv
// spi_gate_burst: mode-0 SPI slave turning address+burst frames into register port cycles.
module spi_gate_burst
    import spi_gate_burst_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int AUTO_INC    = 1,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic n_rst,
    spi_gate_burst_if.slave bus
);
    localparam int CW = clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
    if (!cfg_ok(ADDR_W, DATA_W, SYNC_STAGES)) begin : g_bad_cfg
        $error("spi_gate_burst: parameter out of range");
    end
    state_t state, state_nx;
    logic s_sclk, s_mosi, s_ncs, sclk_q, rise, armed, sel, rxe;
    logic [SYNC_STAGES-1:0] warm;
    logic [CW-1:0] cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] shift, rxd;
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(clk), .n_rst(n_rst), .d(bus.sclk), .q(s_sclk));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(clk), .n_rst(n_rst), .d(bus.mosi), .q(s_mosi));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (.clk(clk), .n_rst(n_rst), .d(bus.n_cs), .q(s_ncs));
    assign rise = s_sclk & ~sclk_q;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= ST_IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (s_ncs) state_nx = ST_IDLE;
        else case (state)
            ST_IDLE: state_nx = armed ? ST_ADDR : ST_IDLE;
            ST_ADDR: state_nx = rise && cnt == CW'(ADDR_W - 1) ? ST_LOAD : ST_ADDR;
            ST_LOAD: state_nx = cnt == CW'(TXE_CYCLES - 1) ? ST_DATA : ST_LOAD;
            ST_DATA: state_nx = cnt == CW'(DATA_W) ? ST_LOAD : ST_DATA;
            default: state_nx = ST_IDLE;
        endcase
    end
    // The nCS synchroniser resets high, so arming waits until it holds a real pin sample.
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            warm   <= '0;
            armed  <= 1'b0;
            sclk_q <= 1'b0;
            cnt    <= '0;
            addr   <= '0;
            shift  <= '0;
            rxd    <= '0;
            sel    <= 1'b0;
            rxe    <= 1'b0;
        end else begin
            warm   <= {warm[SYNC_STAGES-2:0], 1'b1};
            armed  <= armed | (warm[SYNC_STAGES-1] & s_ncs);
            sclk_q <= s_sclk;
            rxe    <= 1'b0;
            if (s_ncs) begin
                cnt <= '0;
                sel <= 1'b0;
            end else case (state)
                ST_IDLE: cnt <= '0;
                ST_ADDR: if (rise) begin
                    addr <= ADDR_W'({addr, s_mosi});
                    cnt  <= cnt == CW'(ADDR_W - 1) ? '0 : cnt + CW'(1);
                    if (cnt == CW'(ADDR_W - 1)) sel <= 1'b1;
                end
                ST_LOAD: begin
                    cnt <= cnt == CW'(TXE_CYCLES - 1) ? '0 : cnt + CW'(1);
                    if (cnt == CW'(TXE_CYCLES - 1)) shift <= bus.txd;
                end
                ST_DATA: if (cnt == CW'(DATA_W)) begin
                    cnt <= '0;
                    if (AUTO_INC != 0) addr <= addr + ADDR_W'(1);
                end else if (rise) begin
                    shift <= DATA_W'({shift, s_mosi});
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(DATA_W - 1)) begin
                        rxd <= DATA_W'({shift, s_mosi});
                        rxe <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    assign bus.miso = state == ST_DATA && shift[DATA_W-1];
    assign bus.txe  = state == ST_LOAD;
    assign bus.sel  = sel;
    assign bus.rxe  = rxe;
    assign bus.rxd  = rxd;
    assign bus.addr = addr;
endmodule

// File: tb/tb_spi_gate_burst.sv
// tb_spi_gate_burst: host bit-bangs frames into two gateway configurations and scores the port side.
module tb_spi_gate_burst;
    logic clk = 0, n_rst = 0;
    logic sclk = 0, mosi = 0, ncs_a = 1, ncs_b = 1, dut_b = 0;
    logic [7:0] txd_a = 0;
    logic [15:0] txd_b = 0;
    int n_cmp = 0, n_err = 0, txe_run = 0;
    logic sel_seen = 0;
    logic [31:0] txq[$], sent[$], rx_data[$];
    logic [15:0] rx_addr[$];
    logic [31:0] wdata[8], rdata[8];
    always #10 clk = ~clk;
    spi_gate_burst_if #(.ADDR_W(8), .DATA_W(8)) ia ();
    spi_gate_burst_if #(.ADDR_W(7), .DATA_W(16)) ib ();
    assign ia.sclk = sclk;
    assign ia.mosi = mosi;
    assign ia.n_cs = ncs_a;
    assign ia.txd  = txd_a;
    assign ib.sclk = sclk;
    assign ib.mosi = mosi;
    assign ib.n_cs = ncs_b;
    assign ib.txd  = txd_b;
    spi_gate_burst u_a (.clk(clk), .n_rst(n_rst), .bus(ia.slave));
    spi_gate_burst #(.ADDR_W(7), .DATA_W(16), .AUTO_INC(0), .SYNC_STAGES(3)) u_b (.clk(clk), .n_rst(n_rst), .bus(ib.slave));
    logic miso_m, sel_m, txe_m, rxe_m;
    logic [15:0] addr_m;
    logic [31:0] rxd_m;
    assign miso_m = dut_b ? ib.miso : ia.miso;
    assign sel_m  = dut_b ? ib.sel : ia.sel;
    assign txe_m  = dut_b ? ib.txe : ia.txe;
    assign rxe_m  = dut_b ? ib.rxe : ia.rxe;
    assign addr_m = dut_b ? 16'(ib.addr) : 16'(ia.addr);
    assign rxd_m  = dut_b ? 32'(ib.rxd) : 32'(ia.rxd);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register port model: supplies the next queued word on each fetch and records it.
    always @(negedge clk) begin
        logic [31:0] v;
        if (rxe_m) begin
            rx_addr.push_back(addr_m);
            rx_data.push_back(rxd_m);
        end
        if (sel_m) sel_seen = 1;
        if (txe_m) begin
            if (txe_run == 0) begin
                v = txq.size() != 0 ? txq.pop_front() : $urandom;
                v = v & (dut_b ? 32'hFFFF : 32'hFF);
                sent.push_back(v);
                if (dut_b) txd_b = v[15:0];
                else txd_a = v[7:0];
            end
            txe_run++;
        end else if (txe_run != 0) begin
            chk("txe_len", txe_run, 2);
            txe_run = 0;
        end
    end

    task automatic clear();
        rx_addr.delete();
        rx_data.delete();
        sent.delete();
        txq.delete();
        sel_seen = 0;
    endtask

    task automatic spi_bits(input int n, input logic [31:0] out, input int h, output logic [31:0] inp);
        inp = 0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = out[i];
            repeat (h) @(negedge clk);
            inp = {inp[30:0], miso_m};
            sclk = 1;
            repeat (h) @(negedge clk);
            sclk = 0;
        end
    endtask

    task automatic frame(input int aw, input int dw, input logic [31:0] ad, input int nw, input int h, input int abort);
        logic [31:0] r;
        if (dut_b) ncs_b = 0;
        else ncs_a = 0;
        repeat (h) @(negedge clk);
        spi_bits(aw - 1, ad >> 1, h, r);
        chk("sel_early", sel_m, 0);
        spi_bits(1, ad, h, r);
        chk("sel_addr", sel_m, 1);
        for (int w = 0; w < nw; w++) begin
            spi_bits(dw, wdata[w], h, r);
            rdata[w] = r;
        end
        if (abort != 0) spi_bits(abort, 32'h1F, h, r);
        repeat (h) @(negedge clk);
        if (dut_b) ncs_b = 1;
        else ncs_a = 1;
        repeat (2 * h) @(negedge clk);
    endtask

    task automatic verify(input int aw, input int dw, input logic [31:0] ad, input int nw, input bit inc);
        logic [31:0] mask;
        mask = dw == 8 ? 32'hFF : 32'hFFFF;
        chk("rxe_count", rx_data.size(), nw);
        chk("fetches", sent.size(), nw + 1);
        for (int w = 0; w < nw && w < rx_data.size() && w < sent.size(); w++) begin
            chk($sformatf("rxd%0d", w), rx_data[w], wdata[w] & mask);
            chk($sformatf("rx_addr%0d", w), rx_addr[w], inc ? (ad + w) % (1 << aw) : ad);
            chk($sformatf("miso%0d", w), rdata[w], sent[w]);
        end
        chk("sel_end", sel_m, 0);
        chk("txe_end", txe_m, 0);
    endtask

    initial begin
        logic [31:0] r, ad;
        repeat (5) @(negedge clk);
        n_rst = 1;
        repeat (5) @(negedge clk);
        chk("rst_sel", ia.sel, 0);
        chk("rst_txe", ia.txe, 0);
        chk("rst_rxe", ia.rxe, 0);
        chk("rst_addr", ia.addr, 0);
        chk("rst_rxd", ia.rxd, 0);
        chk("rst_miso", ia.miso, 0);
        // single word
        clear();
        wdata[0] = 'hA5;
        txq.push_back('h3C);
        frame(8, 8, 'h05, 1, 12, 0);
        verify(8, 8, 'h05, 1, 1);
        chk("t1_host_read", rdata[0], 'h3C);
        // burst with address wrap
        clear();
        wdata[0] = 'h11; wdata[1] = 'h22; wdata[2] = 'h33;
        frame(8, 8, 'hFE, 3, 12, 0);
        verify(8, 8, 'hFE, 3, 1);
        chk("t2_addr_after", addr_m, 'h01);
        // wide words, fixed address
        dut_b = 1;
        clear();
        wdata[0] = 'hBEEF; wdata[1] = 'h1234;
        repeat (3) txq.push_back('hCAFE);
        frame(7, 16, 'h7F, 2, 12, 0);
        verify(7, 16, 'h7F, 2, 0);
        chk("t3_read0", rdata[0], 'hCAFE);
        chk("t3_read1", rdata[1], 'hCAFE);
        dut_b = 0;
        // aborted word then clean frame
        clear();
        frame(8, 8, 'h10, 0, 12, 5);
        verify(8, 8, 'h10, 0, 1);
        clear();
        wdata[0] = 'h81;
        frame(8, 8, 'h02, 1, 12, 0);
        verify(8, 8, 'h02, 1, 1);
        // reset in the middle of the address phase with nCS held low
        clear();
        ncs_a = 0;
        repeat (12) @(negedge clk);
        spi_bits(3, 32'h5, 12, r);
        n_rst = 0;
        repeat (3) @(negedge clk);
        n_rst = 1;
        spi_bits(5, 32'h0, 12, r);
        spi_bits(8, 32'h5A, 12, r);
        spi_bits(8, 32'hC3, 12, r);
        repeat (12) @(negedge clk);
        ncs_a = 1;
        repeat (24) @(negedge clk);
        chk("t5_no_rxe", rx_data.size(), 0);
        chk("t5_no_txe", sent.size(), 0);
        chk("t5_no_sel", sel_seen, 0);
        clear();
        wdata[0] = 'h96;
        frame(8, 8, 'h33, 1, 12, 0);
        verify(8, 8, 'h33, 1, 1);
        // minimum SCLK phase, random burst
        for (int k = 0; k < 2; k++) begin
            clear();
            ad = $urandom_range(0, 255);
            for (int w = 0; w < 4; w++) begin
                wdata[w] = $urandom_range(0, 255);
                txq.push_back($urandom_range(0, 255));
            end
            frame(8, 8, ad, 4, 6, 0);
            verify(8, 8, ad, 4, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
